alu_issue_stage: RTL and testbench

//  Driving end of the abstracted-ALU interface. Holds the ID/EX issue register that supplies
//  the ALU with rdat1, rdat2, immediate, ALUSrc and ALUOP. Resolves operand forwarding, then

---
 rtl/alu_issue_stage.sv | 192 +++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//   Driving end of the abstracted-ALU interface. An ID/EX issue register (E)
//   presents rdat1/rdat2/immediate/ALUSrc/ALUOP to an external combinational
//   ALU, with operand forwarding from the EX/MEM result register (R) and from
//   the writeback port. The ALU outputs are captured into R. Both the decode
//   side and the memory side use valid/ready handshakes.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   flush               squash the issue register at the next edge
//   in_valid/in_ready   decode-side handshake
//   in_rdat1/2, in_imm  operand values, in_alusrc/in_aluop control
//   in_rs/in_rt/in_rd   source/destination registers, in_regwen writes rd
//   wb_wen/wsel/wdat    register-file writeback, used as a forwarding source
//   alu_*  (out)        forwarded operands and control to the ALU
//   alu_*  (in)         ALU result and zero/over/neg flags
//   out_valid/out_ready memory-side handshake
//   out_result, out_zero/over/neg, out_rd, out_regwen   registered result
// ---------------------------------------------------------------------------
module alu_issue_stage #(
   parameter int WIDTH = 32,
   parameter int OPW   = 4,
   parameter int REGW  = 5
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_rdat1,
   input  logic [WIDTH-1:0] in_rdat2,
   input  logic [WIDTH-1:0] in_imm,
   input  logic             in_alusrc,
   input  logic [OPW-1:0]   in_aluop,
   input  logic [REGW-1:0]  in_rs,
   input  logic [REGW-1:0]  in_rt,
   input  logic [REGW-1:0]  in_rd,
   input  logic             in_regwen,
   input  logic             wb_wen,
   input  logic [REGW-1:0]  wb_wsel,
   input  logic [WIDTH-1:0] wb_wdat,
   output logic [WIDTH-1:0] alu_rdat1,
   output logic [WIDTH-1:0] alu_rdat2,
   output logic [WIDTH-1:0] alu_imm,
   output logic             alu_alusrc,
   output logic [OPW-1:0]   alu_aluop,
   input  logic [WIDTH-1:0] alu_outport,
   input  logic             alu_zero,
   input  logic             alu_over,
   input  logic             alu_neg,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_zero,
   output logic             out_over,
   output logic             out_neg,
   output logic [REGW-1:0]  out_rd,
   output logic             out_regwen
);

   // Issue register (E)
   logic             r_e_valid;
   logic [WIDTH-1:0] r_e_rdat1;
   logic [WIDTH-1:0] r_e_rdat2;
   logic [WIDTH-1:0] r_e_imm;
   logic             r_e_alusrc;
   logic [OPW-1:0]   r_e_aluop;
   logic [REGW-1:0]  r_e_rs;
   logic [REGW-1:0]  r_e_rt;
   logic [REGW-1:0]  r_e_rd;
   logic             r_e_regwen;

   // Result register (R)
   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_result;
   logic             r_out_zero;
   logic             r_out_over;
   logic             r_out_neg;
   logic [REGW-1:0]  r_out_rd;
   logic             r_out_regwen;

   logic             w_r_adv;
   logic             w_e_adv;
   logic             w_load_e;
   logic [WIDTH-1:0] w_fwd_a;
   logic [WIDTH-1:0] w_fwd_b;

   // Operand forwarding: R first, then writeback, then the captured value.
   // Register 0 is hard-wired and never forwarded.
   function automatic logic [WIDTH-1:0] f_fwd(
      input logic [REGW-1:0]  src,
      input logic [WIDTH-1:0] cap,
      input logic             r_hit_en,
      input logic [REGW-1:0]  r_rd,
      input logic [WIDTH-1:0] r_res,
      input logic             wb_en,
      input logic [REGW-1:0]  wb_sel,
      input logic [WIDTH-1:0] wb_dat
   );
      logic [WIDTH-1:0] v;
      v = cap;
      if (src != '0) begin
         if (r_hit_en && (r_rd == src))
            v = r_res;
         else if (wb_en && (wb_sel == src))
            v = wb_dat;
      end
      return v;
   endfunction

   assign w_r_adv  = ~r_out_valid | out_ready;
   assign w_e_adv  = ~r_e_valid | w_r_adv;
   assign w_load_e = in_valid & ~flush;
   assign in_ready = w_e_adv;

   assign w_fwd_a = f_fwd(r_e_rs, r_e_rdat1, r_out_valid & r_out_regwen, r_out_rd,
                          r_out_result, wb_wen, wb_wsel, wb_wdat);
   assign w_fwd_b = f_fwd(r_e_rt, r_e_rdat2, r_out_valid & r_out_regwen, r_out_rd,
                          r_out_result, wb_wen, wb_wsel, wb_wdat);

   assign alu_rdat1  = w_fwd_a;
   assign alu_rdat2  = w_fwd_b;
   assign alu_imm    = r_e_imm;
   assign alu_alusrc = r_e_alusrc;
   assign alu_aluop  = r_e_aluop;

   // ---- Stage boundary: decode -> issue register ----
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_e_valid  <= 1'b0;
         r_e_rdat1  <= '0;
         r_e_rdat2  <= '0;
         r_e_imm    <= '0;
         r_e_alusrc <= 1'b0;
         r_e_aluop  <= '0;
         r_e_rs     <= '0;
         r_e_rt     <= '0;
         r_e_rd     <= '0;
         r_e_regwen <= 1'b0;
      end else if (w_e_adv) begin
         r_e_valid <= w_load_e;
         if (w_load_e) begin
            r_e_rdat1  <= in_rdat1;
            r_e_rdat2  <= in_rdat2;
            r_e_imm    <= in_imm;
            r_e_alusrc <= in_alusrc;
            r_e_aluop  <= in_aluop;
            r_e_rs     <= in_rs;
            r_e_rt     <= in_rt;
            r_e_rd     <= in_rd;
            r_e_regwen <= in_regwen;
         end
      end else begin
         // Stalled with a valid entry: latch forwarded operands so a value
         // draining out of R or writeback this cycle is not lost.
         r_e_valid <= ~flush;
         r_e_rdat1 <= w_fwd_a;
         r_e_rdat2 <= w_fwd_b;
      end
   end

   // ---- Stage boundary: issue register -> EX/MEM result register ----
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_zero   <= 1'b0;
         r_out_over   <= 1'b0;
         r_out_neg    <= 1'b0;
         r_out_rd     <= '0;
         r_out_regwen <= 1'b0;
      end else if (w_r_adv) begin
         r_out_valid  <= r_e_valid;
         r_out_result <= alu_outport;
         r_out_zero   <= alu_zero;
         r_out_over   <= alu_over;
         r_out_neg    <= alu_neg;
         r_out_rd     <= r_e_rd;
         r_out_regwen <= r_e_regwen & (r_e_rd != '0);
      end
   end

   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;
   assign out_zero   = r_out_zero;
   assign out_over   = r_out_over;
   assign out_neg    = r_out_neg;
   assign out_rd     = r_out_rd;
   assign out_regwen = r_out_regwen;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Testbench for alu_issue_stage: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level model of the two stages.
module tb_alu_issue_stage;
   localparam int WIDTH = 32;
   localparam int OPW   = 4;
   localparam int REGW  = 5;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic             RST, flush, in_valid, in_ready;
   logic [WIDTH-1:0] in_rdat1, in_rdat2, in_imm;
   logic             in_alusrc;
   logic [OPW-1:0]   in_aluop;
   logic [REGW-1:0]  in_rs, in_rt, in_rd;
   logic             in_regwen;
   logic             wb_wen;
   logic [REGW-1:0]  wb_wsel;
   logic [WIDTH-1:0] wb_wdat;
   logic [WIDTH-1:0] alu_rdat1, alu_rdat2, alu_imm;
   logic             alu_alusrc;
   logic [OPW-1:0]   alu_aluop;
   logic [WIDTH-1:0] alu_outport;
   logic             alu_zero, alu_over, alu_neg;
   logic             out_valid, out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_zero, out_over, out_neg;
   logic [REGW-1:0]  out_rd;
   logic             out_regwen;

   int n_cmp = 0;
   int n_err = 0;

   alu_issue_stage #(.WIDTH(WIDTH), .OPW(OPW), .REGW(REGW)) dut (
      .CLK(CLK), .RST(RST), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rdat1(in_rdat1), .in_rdat2(in_rdat2), .in_imm(in_imm),
      .in_alusrc(in_alusrc), .in_aluop(in_aluop),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_regwen(in_regwen),
      .wb_wen(wb_wen), .wb_wsel(wb_wsel), .wb_wdat(wb_wdat),
      .alu_rdat1(alu_rdat1), .alu_rdat2(alu_rdat2), .alu_imm(alu_imm),
      .alu_alusrc(alu_alusrc), .alu_aluop(alu_aluop),
      .alu_outport(alu_outport), .alu_zero(alu_zero), .alu_over(alu_over), .alu_neg(alu_neg),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_zero(out_zero), .out_over(out_over), .out_neg(out_neg),
      .out_rd(out_rd), .out_regwen(out_regwen)
   );

   // Behavioural ALU: returns {over, neg, zero, result}
   function automatic logic [34:0] alu_eval(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [31:0] r;
      logic        ov;
      ov = 1'b0;
      case (op)
         4'd0: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
         4'd1: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         default: r = 32'd0;
      endcase
      return {ov, r[31], (r == 32'd0), r};
   endfunction

   always_comb {alu_over, alu_neg, alu_zero, alu_outport} =
      alu_eval(alu_aluop, alu_rdat1, alu_alusrc ? alu_imm : alu_rdat2);

   // Reference model: one slot per stage
   typedef struct packed {
      logic v; logic [31:0] a; logic [31:0] b; logic [31:0] imm; logic src;
      logic [3:0] op; logic [4:0] rs; logic [4:0] rt; logic [4:0] rd; logic wen;
   } e_t;
   typedef struct packed {
      logic v; logic [31:0] res; logic z; logic o; logic n; logic [4:0] rd; logic wen;
   } r_t;
   e_t mE = '0;
   r_t mR = '0;

   function automatic logic [31:0] m_fwd(input logic [4:0] s, input logic [31:0] cap);
      if (s != 5'd0 && mR.v && mR.wen && mR.rd == s) return mR.res;
      if (s != 5'd0 && wb_wen && wb_wsel == s) return wb_wdat;
      return cap;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Called at a falling edge with inputs applied; checks this cycle, advances the model,
   // and returns at the next falling edge.
   task automatic step();
      logic [31:0] fa, fb;
      logic        radv, eadv;
      logic [34:0] ar;
      e_t nE;
      r_t nR;
      #1;
      radv = !mR.v || out_ready;
      eadv = !mE.v || radv;
      fa = m_fwd(mE.rs, mE.a);
      fb = m_fwd(mE.rt, mE.b);
      check("in_ready",   in_ready,   eadv);
      check("alu_rdat1",  alu_rdat1,  fa);
      check("alu_rdat2",  alu_rdat2,  fb);
      check("alu_imm",    alu_imm,    mE.imm);
      check("alu_alusrc", alu_alusrc, mE.src);
      check("alu_aluop",  alu_aluop,  mE.op);
      check("out_valid",  out_valid,  mR.v);
      check("out_result", out_result, mR.res);
      check("out_flags",  {out_zero, out_over, out_neg}, {mR.z, mR.o, mR.n});
      check("out_rd",     out_rd,     mR.rd);
      check("out_regwen", out_regwen, mR.wen);
      nE = mE;
      nR = mR;
      if (RST) begin
         nE = '0;
         nR = '0;
      end else begin
         if (radv) begin
            ar = alu_eval(mE.op, fa, mE.src ? mE.imm : fb);
            nR.v = mE.v; nR.res = ar[31:0]; nR.z = ar[32]; nR.n = ar[33]; nR.o = ar[34];
            nR.rd = mE.rd; nR.wen = mE.wen && (mE.rd != 5'd0);
         end
         if (eadv) begin
            nE.v = in_valid && !flush;
            if (in_valid && !flush) begin
               nE.a = in_rdat1; nE.b = in_rdat2; nE.imm = in_imm; nE.src = in_alusrc;
               nE.op = in_aluop; nE.rs = in_rs; nE.rt = in_rt; nE.rd = in_rd; nE.wen = in_regwen;
            end
         end else begin
            nE.a = fa;
            nE.b = fb;
            if (flush) nE.v = 1'b0;
         end
      end
      mE = nE;
      mR = nR;
      @(negedge CLK);
   endtask

   task automatic quiet();
      RST = 1'b0; flush = 1'b0; in_valid = 1'b0; wb_wen = 1'b0; wb_wsel = '0; wb_wdat = '0;
      out_ready = 1'b1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [4:0] rs, input logic [31:0] a,
                        input logic [4:0] rt, input logic [31:0] b, input logic [4:0] rd,
                        input logic wen, input logic src, input logic [31:0] imm);
      in_valid = 1'b1; in_aluop = op; in_rs = rs; in_rdat1 = a; in_rt = rt; in_rdat2 = b;
      in_rd = rd; in_regwen = wen; in_alusrc = src; in_imm = imm;
   endtask

   initial begin
      quiet();
      in_rdat1 = '0; in_rdat2 = '0; in_imm = '0; in_alusrc = 1'b0; in_aluop = '0;
      in_rs = '0; in_rt = '0; in_rd = '0; in_regwen = 1'b0;
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_result", out_result, 32'd0);

      // Back-to-back issue
      issue(OP_ADD, 5'd1, 32'd5, 5'd2, 32'd7, 5'd10, 1'b1, 1'b0, 32'd0); step();
      issue(OP_SUB, 5'd3, 32'd30, 5'd4, 32'd8, 5'd11, 1'b1, 1'b0, 32'd0); step();
      in_valid = 1'b0;
      check("b2b_v0", out_valid, 1'b1);
      check("b2b_add", out_result, 32'd12);
      step();
      check("b2b_v1", out_valid, 1'b1);
      check("b2b_sub", out_result, 32'd22);

      // EX/MEM forward, then the same with rd=0
      issue(OP_ADD, 5'd1, 32'h10, 5'd0, 32'd0, 5'd8, 1'b1, 1'b0, 32'd0); step();
      issue(OP_ADD, 5'd8, 32'd0, 5'd0, 32'd1, 5'd9, 1'b1, 1'b0, 32'd0); step();
      check("fwd_a", alu_rdat1, 32'h10);
      in_valid = 1'b0; step();
      check("fwd_res", out_result, 32'h11);
      issue(OP_ADD, 5'd1, 32'h10, 5'd0, 32'd0, 5'd0, 1'b1, 1'b0, 32'd0); step();
      issue(OP_ADD, 5'd0, 32'd0, 5'd0, 32'd1, 5'd14, 1'b1, 1'b0, 32'd0); step();
      check("r0_regwen", out_regwen, 1'b0);
      check("r0_nofwd", alu_rdat1, 32'd0);
      in_valid = 1'b0; step();
      check("r0_res", out_result, 32'd1);

      // Stall with WB forward into a held entry
      issue(OP_ADD, 5'd1, 32'd3, 5'd2, 32'd4, 5'd12, 1'b1, 1'b0, 32'd0); step();
      issue(OP_ADD, 5'd0, 32'd1, 5'd9, 32'd0, 5'd13, 1'b1, 1'b0, 32'd0); step();
      out_ready = 1'b0;
      issue(OP_ADD, 5'd1, 32'd99, 5'd2, 32'd99, 5'd15, 1'b1, 1'b0, 32'd0); step();
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_hold", out_result, 32'd7);
      wb_wen = 1'b1; wb_wsel = 5'd9; wb_wdat = 32'hAB; step();
      check("stall_wb", alu_rdat2, 32'hAB);
      wb_wen = 1'b0; step();
      check("stall_keep", alu_rdat2, 32'hAB);
      check("stall_hold2", out_result, 32'd7);
      out_ready = 1'b1; in_valid = 1'b0; step();
      check("stall_res", out_result, 32'hAC);

      // Flush: E advances, incoming dropped, bubble follows
      issue(OP_ADD, 5'd1, 32'd2, 5'd2, 32'd3, 5'd5, 1'b1, 1'b0, 32'd0); step();
      flush = 1'b1;
      issue(OP_ADD, 5'd1, 32'd100, 5'd2, 32'd1, 5'd6, 1'b1, 1'b0, 32'd0); step();
      check("flush_adv_v", out_valid, 1'b1);
      check("flush_adv", out_result, 32'd5);
      flush = 1'b0; in_valid = 1'b0; step();
      check("flush_bubble", out_valid, 1'b0);

      // Reset with both stages full
      issue(OP_ADD, 5'd1, 32'd1, 5'd2, 32'd1, 5'd5, 1'b1, 1'b0, 32'd0); step();
      out_ready = 1'b0;
      issue(OP_ADD, 5'd1, 32'd2, 5'd2, 32'd2, 5'd6, 1'b1, 1'b0, 32'd0); step();
      check("full_before_rst", out_valid, 1'b1);
      RST = 1'b1; in_valid = 1'b0; step();
      RST = 1'b0;
      check("rst2_out_valid", out_valid, 1'b0);
      check("rst2_in_ready", in_ready, 1'b1);
      check("rst2_out_result", out_result, 32'd0);
      check("rst2_alu_rdat1", alu_rdat1, 32'd0);

      // Flags
      out_ready = 1'b1;
      issue(OP_ADD, 5'd1, 32'h7FFF_FFFF, 5'd0, 32'd0, 5'd6, 1'b1, 1'b1, 32'd1); step();
      issue(OP_SUB, 5'd2, 32'd5, 5'd3, 32'd5, 5'd7, 1'b1, 1'b0, 32'd0); step();
      check("ovf_res", out_result, 32'h8000_0000);
      check("ovf_over", out_over, 1'b1);
      check("ovf_neg", out_neg, 1'b1);
      in_valid = 1'b0; step();
      check("sub_zero", out_zero, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_aluop  = 4'($urandom_range(0, 5));
         in_rs     = 5'($urandom_range(0, 7));
         in_rt     = 5'($urandom_range(0, 7));
         in_rd     = 5'($urandom_range(0, 7));
         in_regwen = ($urandom_range(0, 3) != 0);
         in_alusrc = $urandom_range(0, 1) == 1;
         in_rdat1  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
         in_rdat2  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
         in_imm    = $urandom;
         wb_wen    = ($urandom_range(0, 9) < 3);
         wb_wsel   = 5'($urandom_range(0, 7));
         wb_wdat   = $urandom;
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 19) == 0);
         RST       = ($urandom_range(0, 99) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
